// File: rtl/sram_arbiter.sv
// Shares one external 128Kx8 SRAM between the CPU bus port and the video fetch port.
// Each SRAM cycle runs SETUP -> ACCESS (ACCESS_CYCLES) -> DONE with fully registered pins.
module sram_arbiter #(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter logic        VID_BANK      = 1'b0
) (
   input  logic        clk_in,
   input  logic        b_reset,
   input  logic        cpu_req,
   input  logic        cpu_rw,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   input  logic        vid_req,
   input  logic [15:0] vid_addr,
   output logic [7:0]  vid_rdata,
   output logic        vid_ack,
   output logic [16:0] SRAM_AD,
   inout  wire  [7:0]  SRAM_DQ,
   output logic        SRAM_WE_n,
   output logic        SRAM_OE_n,
   output logic        SRAM_CS2
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;

   localparam logic [2:0] CNT_INIT = 3'(ACCESS_CYCLES - 1);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;

   logic        cpu_pend_q, cpu_rw_q;
   logic [15:0] cpu_addr_q;
   logic [7:0]  cpu_wdata_q;
   logic        vid_pend_q;
   logic [15:0] vid_addr_q;

   logic        last_vid_q, last_vid_d;
   logic        gnt_vid_q, gnt_vid_d;
   logic        gnt_rd_q, gnt_rd_d;
   logic        grant_cpu, grant_vid;

   logic [16:0] ad_q, ad_d;
   logic [7:0]  dq_out_q, dq_out_d;
   logic        dq_oe_q, dq_oe_d;
   logic        we_n_q, we_n_d;
   logic        oe_n_q, oe_n_d;
   logic        cs2_q, cs2_d;
   logic        cpu_ack_q, cpu_ack_d;
   logic        vid_ack_q, vid_ack_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;
   logic [7:0]  vid_rdata_q, vid_rdata_d;

   // Request latches: a pending source ignores new pulses, except on its grant edge where set wins.
   always_ff @(posedge clk_in or negedge b_reset) begin
      if (!b_reset) begin
         cpu_pend_q  <= 1'b0;
         cpu_rw_q    <= 1'b1;
         cpu_addr_q  <= '0;
         cpu_wdata_q <= '0;
         vid_pend_q  <= 1'b0;
         vid_addr_q  <= '0;
      end else begin
         if (cpu_req && (!cpu_pend_q || grant_cpu)) begin
            cpu_pend_q  <= 1'b1;
            cpu_rw_q    <= cpu_rw;
            cpu_addr_q  <= cpu_addr;
            cpu_wdata_q <= cpu_wdata;
         end else if (grant_cpu) begin
            cpu_pend_q  <= 1'b0;
         end
         if (vid_req && (!vid_pend_q || grant_vid)) begin
            vid_pend_q <= 1'b1;
            vid_addr_q <= vid_addr;
         end else if (grant_vid) begin
            vid_pend_q <= 1'b0;
         end
      end
   end

   // State register
   always_ff @(posedge clk_in or negedge b_reset) begin
      if (!b_reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         last_vid_q <= 1'b0;
         gnt_vid_q  <= 1'b0;
         gnt_rd_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_vid_q <= last_vid_d;
         gnt_vid_q  <= gnt_vid_d;
         gnt_rd_q   <= gnt_rd_d;
      end
   end

   // Next-state and round-robin arbitration
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_vid_d = last_vid_q;
      gnt_vid_d  = gnt_vid_q;
      gnt_rd_d   = gnt_rd_q;
      grant_cpu  = 1'b0;
      grant_vid  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_pend_q && vid_pend_q) begin
               grant_cpu = last_vid_q;
               grant_vid = !last_vid_q;
            end else begin
               grant_cpu = cpu_pend_q;
               grant_vid = vid_pend_q;
            end
            if (grant_cpu || grant_vid) begin
               state_d    = S_SETUP;
               gnt_vid_d  = grant_vid;
               gnt_rd_d   = grant_vid || cpu_rw_q;
               last_vid_d = grant_vid;
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
            cnt_d   = CNT_INIT;
         end
         S_ACCESS: begin
            if (cnt_q == 3'd0) state_d = S_DONE;
            else               cnt_d   = cnt_q - 3'd1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pin and ack values for the coming state; registered below so no input reaches a pin directly.
   always_comb begin
      cs2_d       = 1'b0;
      oe_n_d      = 1'b1;
      we_n_d      = 1'b1;
      dq_oe_d     = 1'b0;
      cpu_ack_d   = 1'b0;
      vid_ack_d   = 1'b0;
      ad_d        = ad_q;
      dq_out_d    = dq_out_q;
      cpu_rdata_d = cpu_rdata_q;
      vid_rdata_d = vid_rdata_q;
      if (grant_cpu) begin
         ad_d     = {1'b0, cpu_addr_q};
         dq_out_d = cpu_wdata_q;
      end
      if (grant_vid) ad_d = {VID_BANK, vid_addr_q};
      case (state_d)
         S_SETUP: begin
            cs2_d   = 1'b1;
            oe_n_d  = !gnt_rd_d;
            dq_oe_d = !gnt_rd_d;
         end
         S_ACCESS: begin
            cs2_d   = 1'b1;
            oe_n_d  = !gnt_rd_d;
            we_n_d  = gnt_rd_d;
            dq_oe_d = !gnt_rd_d;
         end
         S_DONE: begin
            cs2_d     = 1'b1;
            dq_oe_d   = !gnt_rd_d;
            cpu_ack_d = !gnt_vid_d;
            vid_ack_d = gnt_vid_d;
         end
         default: ;
      endcase
      if (state_q == S_ACCESS && state_d == S_DONE && gnt_rd_q) begin
         if (gnt_vid_q) vid_rdata_d = SRAM_DQ;
         else           cpu_rdata_d = SRAM_DQ;
      end
   end

   always_ff @(posedge clk_in or negedge b_reset) begin
      if (!b_reset) begin
         ad_q        <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         cs2_q       <= 1'b0;
         cpu_ack_q   <= 1'b0;
         vid_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         vid_rdata_q <= '0;
      end else begin
         ad_q        <= ad_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
         cs2_q       <= cs2_d;
         cpu_ack_q   <= cpu_ack_d;
         vid_ack_q   <= vid_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         vid_rdata_q <= vid_rdata_d;
      end
   end

   assign SRAM_AD   = ad_q;
   assign SRAM_DQ   = dq_oe_q ? dq_out_q : 8'hzz;
   assign SRAM_WE_n = we_n_q;
   assign SRAM_OE_n = oe_n_q;
   assign SRAM_CS2  = cs2_q;
   assign cpu_ack   = cpu_ack_q;
   assign vid_ack   = vid_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign vid_rdata = vid_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM behavioural model plus ack scoreboard with cycle-exact expectations.
// A second instance built with ACCESS_CYCLES=1 covers the short-strobe timing.
module tb_sram_arbiter;

   logic clk_in = 1'b0;
   logic b_reset;
   always #10 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic        cpu_req, cpu_rw, vid_req;
   logic [15:0] cpu_addr, vid_addr;
   logic [7:0]  cpu_wdata, cpu_rdata, vid_rdata;
   logic        cpu_ack, vid_ack;
   logic [16:0] SRAM_AD;
   wire  [7:0]  SRAM_DQ;
   logic        SRAM_WE_n, SRAM_OE_n, SRAM_CS2;

   logic        a1_cpu_req, a1_cpu_rw, a1_vid_req;
   logic [15:0] a1_cpu_addr, a1_vid_addr;
   logic [7:0]  a1_cpu_wdata, a1_cpu_rdata, a1_vid_rdata;
   logic        a1_cpu_ack, a1_vid_ack;
   logic [16:0] a1_AD;
   wire  [7:0]  a1_DQ;
   logic        a1_WE_n, a1_OE_n, a1_CS2;

   sram_arbiter #(.ACCESS_CYCLES(2), .VID_BANK(1'b1)) dut (
      .clk_in(clk_in), .b_reset(b_reset),
      .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
      .SRAM_AD(SRAM_AD), .SRAM_DQ(SRAM_DQ), .SRAM_WE_n(SRAM_WE_n),
      .SRAM_OE_n(SRAM_OE_n), .SRAM_CS2(SRAM_CS2));

   sram_arbiter #(.ACCESS_CYCLES(1), .VID_BANK(1'b0)) dut1 (
      .clk_in(clk_in), .b_reset(b_reset),
      .cpu_req(a1_cpu_req), .cpu_rw(a1_cpu_rw), .cpu_addr(a1_cpu_addr), .cpu_wdata(a1_cpu_wdata),
      .cpu_rdata(a1_cpu_rdata), .cpu_ack(a1_cpu_ack),
      .vid_req(a1_vid_req), .vid_addr(a1_vid_addr), .vid_rdata(a1_vid_rdata), .vid_ack(a1_vid_ack),
      .SRAM_AD(a1_AD), .SRAM_DQ(a1_DQ), .SRAM_WE_n(a1_WE_n),
      .SRAM_OE_n(a1_OE_n), .SRAM_CS2(a1_CS2));

   // SRAM models: drive on output enable, store on the rising write strobe.
   logic [7:0] mem  [0:131071];
   logic [7:0] mem1 [0:131071];
   logic       probe_en = 1'b0;
   assign SRAM_DQ = (SRAM_CS2 && !SRAM_OE_n) ? mem[SRAM_AD] : 8'hzz;
   assign SRAM_DQ = probe_en ? 8'h96 : 8'hzz;
   assign a1_DQ   = (a1_CS2 && !a1_OE_n) ? mem1[a1_AD] : 8'hzz;
   always @(posedge SRAM_WE_n) if (SRAM_CS2 === 1'b1) mem[SRAM_AD] = SRAM_DQ;

   typedef struct {
      logic       rd;
      logic [7:0] data;
      int         cyc;
   } exp_t;
   exp_t cpu_q[$];
   exp_t vid_q[$];
   exp_t ce, ve;

   always @(negedge clk_in) begin
      if (cpu_ack === 1'b1) begin
         checks++;
         if (cpu_q.size() == 0) begin
            failures++;
            $display("FAIL cpu_ack_unexpected cyc=%0d", cyc);
         end else begin
            ce = cpu_q.pop_front();
            if (cyc != ce.cyc) begin
               failures++;
               $display("FAIL cpu_ack_cycle got=%0d exp=%0d", cyc, ce.cyc);
            end
            if (ce.rd) begin
               checks++;
               if (cpu_rdata !== ce.data) begin
                  failures++;
                  $display("FAIL cpu_rdata got=%h exp=%h", cpu_rdata, ce.data);
               end
            end
         end
      end
      if (vid_ack === 1'b1) begin
         checks++;
         if (vid_q.size() == 0) begin
            failures++;
            $display("FAIL vid_ack_unexpected cyc=%0d", cyc);
         end else begin
            ve = vid_q.pop_front();
            if (cyc != ve.cyc) begin
               failures++;
               $display("FAIL vid_ack_cycle got=%0d exp=%0d", cyc, ve.cyc);
            end
            checks++;
            if (vid_rdata !== ve.data) begin
               failures++;
               $display("FAIL vid_rdata got=%h exp=%h", vid_rdata, ve.data);
            end
         end
      end
   end

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((cpu_q.size() != 0 || vid_q.size() != 0) && n < budget) begin
         @(negedge clk_in);
         n++;
      end
      repeat (2) @(negedge clk_in);
      checks++;
      if (cpu_q.size() != 0 || vid_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout cpu_left=%0d vid_left=%0d", cpu_q.size(), vid_q.size());
         cpu_q.delete();
         vid_q.delete();
      end
   endtask

   task automatic test_reset();
      b_reset = 1'b0;
      repeat (3) @(negedge clk_in);
      checks++;
      if ({SRAM_WE_n, SRAM_OE_n, SRAM_CS2, cpu_ack, vid_ack} !== 5'b11000) begin
         failures++;
         $display("FAIL reset_pins got=%b exp=11000", {SRAM_WE_n, SRAM_OE_n, SRAM_CS2, cpu_ack, vid_ack});
      end
      checks++;
      if (SRAM_AD !== 17'h0 || cpu_rdata !== 8'h0 || vid_rdata !== 8'h0) begin
         failures++;
         $display("FAIL reset_regs ad=%h cpu_rdata=%h vid_rdata=%h exp=0", SRAM_AD, cpu_rdata, vid_rdata);
      end
      checks++;
      if ({a1_WE_n, a1_OE_n, a1_CS2, a1_cpu_ack, a1_vid_ack} !== 5'b11000) begin
         failures++;
         $display("FAIL reset_pins_ac1 got=%b exp=11000", {a1_WE_n, a1_OE_n, a1_CS2, a1_cpu_ack, a1_vid_ack});
      end
      b_reset = 1'b1;
      repeat (4) @(negedge clk_in);
      checks++;
      if (SRAM_CS2 !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset cs2=%b exp=0", SRAM_CS2);
      end
   endtask

   task automatic test_cpu_read();
      int t;
      @(posedge clk_in); #1;
      t = cyc;
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h1234;
      cpu_q.push_back('{1'b1, 8'hA5, t + 5});
      @(posedge clk_in); #1;
      cpu_req = 1'b0;
      repeat (2) @(negedge clk_in);
      checks++;
      if (SRAM_AD !== 17'h01234 || SRAM_OE_n !== 1'b0 || SRAM_CS2 !== 1'b1) begin
         failures++;
         $display("FAIL read_setup ad=%h oe_n=%b cs2=%b exp ad=01234 oe_n=0 cs2=1", SRAM_AD, SRAM_OE_n, SRAM_CS2);
      end
      wait_drain(20);
      repeat (3) @(negedge clk_in);
      checks++;
      if (cpu_rdata !== 8'hA5) begin
         failures++;
         $display("FAIL read_held got=%h exp=a5", cpu_rdata);
      end
   endtask

   task automatic test_cpu_write();
      logic        we [8];
      logic [16:0] ad [8];
      logic [7:0]  dq [8];
      int lows = 0, lo = -1, hi = -1, t;
      @(posedge clk_in); #1;
      t = cyc;
      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 8'h3C;
      cpu_q.push_back('{1'b0, 8'h00, t + 5});
      @(posedge clk_in); #1;
      cpu_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_in);
         we[i] = SRAM_WE_n; ad[i] = SRAM_AD; dq[i] = SRAM_DQ;
      end
      for (int i = 0; i < 8; i++) begin
         if (we[i] === 1'b0) begin
            lows++;
            if (lo < 0) lo = i;
            hi = i;
            checks++;
            if (dq[i] !== 8'h3C || ad[i] !== 17'h00010) begin
               failures++;
               $display("FAIL write_strobe i=%0d dq=%h ad=%h exp dq=3c ad=00010", i, dq[i], ad[i]);
            end
         end
      end
      checks++;
      if (lows != 2) begin
         failures++;
         $display("FAIL write_we_len got=%0d exp=2", lows);
      end
      checks++;
      if (lo < 1 || hi > 6 || ad[(lo < 1) ? 0 : lo - 1] !== 17'h00010 || ad[(hi > 6) ? 7 : hi + 1] !== 17'h00010) begin
         failures++;
         $display("FAIL write_addr_hold lo=%0d hi=%0d exp address 00010 either side", lo, hi);
      end
      wait_drain(20);
      checks++;
      if (mem[17'h00010] !== 8'h3C) begin
         failures++;
         $display("FAIL write_stored got=%h exp=3c", mem[17'h00010]);
      end
      checks++;
      if (cpu_rdata !== 8'hA5) begin
         failures++;
         $display("FAIL rdata_held_after_write got=%h exp=a5", cpu_rdata);
      end
   endtask

   task automatic test_simultaneous();
      int t;
      @(posedge clk_in); #1;
      t = cyc;
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0055;
      vid_req = 1'b1; vid_addr = 16'h8000;
      vid_q.push_back('{1'b1, 8'hC3, t + 5});
      cpu_q.push_back('{1'b1, 8'h77, t + 10});
      @(posedge clk_in); #1;
      cpu_req = 1'b0; vid_req = 1'b0;
      repeat (2) @(negedge clk_in);
      checks++;
      if (SRAM_AD !== 17'h18000) begin
         failures++;
         $display("FAIL tie_video_first ad=%h exp=18000", SRAM_AD);
      end
      wait_drain(30);
   endtask

   task automatic test_continuous_video();
      int t0;
      @(posedge clk_in); #1;
      t0 = cyc;
      vid_q.push_back('{1'b1, 8'h5A, t0 + 5});
      vid_q.push_back('{1'b1, 8'h5A, t0 + 15});
      vid_q.push_back('{1'b1, 8'h5A, t0 + 20});
      vid_q.push_back('{1'b1, 8'h5A, t0 + 25});
      cpu_q.push_back('{1'b1, 8'h11, t0 + 10});
      for (int k = 0; k < 20; k++) begin
         vid_req = 1'b1; vid_addr = 16'h0100;
         cpu_req = (k == 2); cpu_rw = 1'b1; cpu_addr = 16'h0200;
         @(posedge clk_in); #1;
      end
      vid_req = 1'b0; cpu_req = 1'b0;
      wait_drain(30);
   endtask

   task automatic test_reset_mid_write();
      int t, acks = 0;
      logic cs_seen = 1'b0;
      @(posedge clk_in); #1;
      t = cyc;
      cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0020; cpu_wdata = 8'h99;
      @(posedge clk_in); #1;
      cpu_req = 1'b0;
      repeat (3) @(negedge clk_in);
      checks++;
      if (SRAM_WE_n !== 1'b0) begin
         failures++;
         $display("FAIL mid_write_active we_n=%b exp=0", SRAM_WE_n);
      end
      probe_en = 1'b1;
      #2 b_reset = 1'b0;
      #1;
      checks++;
      if ({SRAM_WE_n, SRAM_OE_n, SRAM_CS2, cpu_ack} !== 4'b1100 || SRAM_AD !== 17'h0) begin
         failures++;
         $display("FAIL async_reset we_n/oe_n/cs2/ack=%b ad=%h exp 1100 ad=0",
                  {SRAM_WE_n, SRAM_OE_n, SRAM_CS2, cpu_ack}, SRAM_AD);
      end
      checks++;
      if (SRAM_DQ !== 8'h96) begin
         failures++;
         $display("FAIL async_reset_dq_released got=%h exp=96", SRAM_DQ);
      end
      @(negedge clk_in);
      probe_en = 1'b0;
      b_reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_in);
         if (cpu_ack === 1'b1) acks++;
         if (SRAM_CS2 !== 1'b0) cs_seen = 1'b1;
      end
      checks++;
      if (acks != 0 || cs_seen) begin
         failures++;
         $display("FAIL post_reset_idle acks=%0d cs2_seen=%b exp 0 0", acks, cs_seen);
      end
      checks++;
      if (cpu_rdata !== 8'h00) begin
         failures++;
         $display("FAIL post_reset_rdata got=%h exp=00", cpu_rdata);
      end
      @(posedge clk_in); #1;
      t = cyc;
      cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0030;
      cpu_q.push_back('{1'b1, 8'h42, t + 5});
      @(posedge clk_in); #1;
      cpu_req = 1'b0;
      wait_drain(20);
   endtask

   task automatic test_access1();
      int t, vc = -1, cc = -1, vn = 0, cn = 0;
      logic [16:0] setup_ad = '0;
      @(posedge clk_in); #1;
      t = cyc;
      a1_cpu_req = 1'b1; a1_cpu_rw = 1'b1; a1_cpu_addr = 16'h0044;
      a1_vid_req = 1'b1; a1_vid_addr = 16'h0066;
      @(posedge clk_in); #1;
      a1_cpu_req = 1'b0; a1_vid_req = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk_in);
         if (cyc == t + 2) setup_ad = a1_AD;
         if (a1_vid_ack === 1'b1) begin vn++; vc = cyc; end
         if (a1_cpu_ack === 1'b1) begin cn++; cc = cyc; end
      end
      checks++;
      if (setup_ad !== 17'h00066) begin
         failures++;
         $display("FAIL ac1_setup_ad got=%h exp=00066", setup_ad);
      end
      checks++;
      if (vn != 1 || vc != t + 4) begin
         failures++;
         $display("FAIL ac1_vid_ack count=%0d cyc=%0d exp 1 at %0d", vn, vc, t + 4);
      end
      checks++;
      if (cn != 1 || cc != t + 8) begin
         failures++;
         $display("FAIL ac1_cpu_ack count=%0d cyc=%0d exp 1 at %0d", cn, cc, t + 8);
      end
      checks++;
      if (a1_vid_rdata !== 8'hD2 || a1_cpu_rdata !== 8'h6E) begin
         failures++;
         $display("FAIL ac1_rdata vid=%h cpu=%h exp d2 6e", a1_vid_rdata, a1_cpu_rdata);
      end
   endtask

   initial begin
      cpu_req = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
      vid_req = 1'b0; vid_addr = '0;
      a1_cpu_req = 1'b0; a1_cpu_rw = 1'b1; a1_cpu_addr = '0; a1_cpu_wdata = '0;
      a1_vid_req = 1'b0; a1_vid_addr = '0;
      mem[17'h01234] = 8'hA5;
      mem[17'h00055] = 8'h77;
      mem[17'h18000] = 8'hC3;
      mem[17'h10100] = 8'h5A;
      mem[17'h00200] = 8'h11;
      mem[17'h00030] = 8'h42;
      mem1[17'h00044] = 8'h6E;
      mem1[17'h00066] = 8'hD2;
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_simultaneous();
      test_continuous_video();
      test_reset_mid_write();
      test_access1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external 128K×8 SRAM between the CPU bus port and the video CRT fetch port, replacing the direct address/rw mux and the CPU hold on video fetch. Runs on the fast `clk_in` domain and sequences every SRAM cycle through address setup, strobe and hold phases. Latches single-cycle requests from either source, arbitrates round-robin when both are pending, and returns registered read data with a one-cycle ack.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 2: `clk_in` cycles the strobe phase (ACCESS) lasts; legal range 1..7.
- `VID_BANK`, default 1'b0: value driven on `SRAM_AD[16]` for video fetches. CPU accesses always drive 0.

Ports:
- `clk_in` in 1: system clock (24 MHz).
- `b_reset` in 1: reset; asynchronous, active-low.
- `cpu_req` in 1: one-cycle request pulse, qualified with `cpu_rw`/`cpu_addr`/`cpu_wdata` in the same cycle.
- `cpu_rw` in 1: 1 = read, 0 = write.
- `cpu_addr` in 16: CPU address.
- `cpu_wdata` in 8: write data.
- `cpu_rdata` out 8: registered read data; held until the next CPU read completes.
- `cpu_ack` out 1: one-cycle completion pulse, for reads and writes.
- `vid_req` in 1: one-cycle fetch request pulse; always a read.
- `vid_addr` in 16: fetch address.
- `vid_rdata` out 8: registered fetch data; held until the next fetch completes.
- `vid_ack` out 1: one-cycle completion pulse.
- `SRAM_AD` out 17: SRAM address.
- `SRAM_DQ` inout 8: SRAM data.
- `SRAM_WE_n` out 1: SRAM write strobe, active low.
- `SRAM_OE_n` out 1: SRAM output enable, active low.
- `SRAM_CS2` out 1: SRAM chip select, active high.

## Operation
- Pending latches:
  - A `cpu_req`/`vid_req` pulse sets `cpu_pend`/`vid_pend` and captures that source's rw/addr/wdata.
  - A request arriving while the same source is already pending is ignored; the first capture stands.
  - A pending flag clears on the edge its source is granted. A new request on that same edge sets it again; set wins.
- FSM states: IDLE → SETUP → ACCESS (`ACCESS_CYCLES` cycles, counted by a 3-bit counter) → DONE → IDLE.
- Arbitration in IDLE:
  - Only one source pending: grant it.
  - Both pending: grant the source not granted last (`last_grant`; reset value CPU, so video wins the first tie).
  - Neither pending: stay in IDLE.
  - Bound: no source waits more than one foreign access.
- On grant, the captured address and data are loaded into the SRAM address/data output registers.
- Pin behaviour per state:
  - IDLE: `SRAM_CS2`=0, `SRAM_OE_n`=1, `SRAM_WE_n`=1, DQ high-Z. `SRAM_AD` holds its last value.
  - SETUP: `SRAM_CS2`=1, `SRAM_AD` valid. Reads drive `SRAM_OE_n`=0. Writes drive DQ and keep `SRAM_WE_n`=1.
  - ACCESS: reads keep `SRAM_OE_n`=0. Writes drive `SRAM_WE_n`=0 with DQ driven.
  - DONE: `SRAM_CS2`=1, `SRAM_WE_n`=1. Write data stays driven for hold. `SRAM_OE_n`=1.
- Read data is sampled from `SRAM_DQ` on the edge ACCESS→DONE into `cpu_rdata` or `vid_rdata`.
- The granted source's ack is 1 during DONE only.
- `SRAM_AD[16]` = `VID_BANK` for video, 0 for CPU. `SRAM_AD[15:0]` = captured address.
- Reset (asynchronous, mid-operation allowed):
  - State → IDLE; pending flags cleared; `last_grant`=CPU.
  - Acks 0, `SRAM_WE_n`=1, `SRAM_OE_n`=1, `SRAM_CS2`=0, DQ high-Z.
  - `SRAM_AD`, `cpu_rdata`, `vid_rdata` = 0.
  - An interrupted access produces no ack and is not retried.

## Timing
- All outputs are registered on the `clk_in` rising edge. No combinational path from inputs to outputs.
- Request sampled at edge E: pending from E; grant at E+1 (SETUP); ACCESS from E+2; DONE from E+2+`ACCESS_CYCLES`.
- Ack is high in the cycle starting at E+2+`ACCESS_CYCLES` (E+4 at the default).
- Access period is `ACCESS_CYCLES`+3 cycles, including the IDLE turnaround; the bus is idle at least one cycle between accesses. Default: 5 cycles = 208 ns at 24 MHz.
- `SRAM_WE_n` low never overlaps an `SRAM_AD` change: address is stable one cycle before and one cycle after the strobe.
- DQ is never driven while `SRAM_OE_n`=0.

## Test plan
- CPU read, `cpu_addr`=16'h1234, SRAM model returns 8'hA5:
  - `SRAM_AD`=17'h01234.
  - `cpu_ack` pulses exactly 4 cycles after the req edge; `cpu_rdata`=8'hA5 and held afterwards.
- CPU write, addr 16'h0010, data 8'h3C:
  - `SRAM_WE_n` low exactly 2 cycles with DQ=8'h3C and address stable one cycle each side.
  - The model stores 3C at that address.
- Simultaneous `cpu_req` and `vid_req` pulses, `VID_BANK`=1, vid_addr 16'h8000:
  - Video is served first with `SRAM_AD`=17'h18000 and its ack comes first.
  - The CPU ack follows 5 cycles later.
- Continuous video requests every cycle plus one CPU request:
  - The CPU is granted after at most one video access.
  - Duplicate video pulses while pending produce only one access each.
- `b_reset` asserted mid-ACCESS of a write:
  - Immediately `SRAM_WE_n`=1, `SRAM_CS2`=0, DQ high-Z, no ack.
  - After release the FSM idles until a new request arrives.
- `ACCESS_CYCLES`=1 build: ack latency 3 cycles, period 4 cycles, read data correct.
